uart_cmd_wrapper: RTL and testbench

- DUT-side responder for the remote command link.
- Deserializes 8N1 UART bytes on RX and assembles each pair into a 16-bit command (high byte first), then presents it to the command processor with a held-ready handshake.
- Serializes 8-bit response bytes (e.g. 0xA5 positive ack) back out on TX.
- Sits between the top-level RX/TX pins and the command-processing FSM.

---
 rtl/uart_cmd_pkg.sv | 13 +
 rtl/uart_rx_core.sv | 111 +++++++++++
 rtl/uart_cmd_wrapper.sv | 172 +++++++++++++++++
 tb/tb_uart_cmd_wrapper.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command wrapper.
// The optional WAIT_LOW timeout is enabled by defining UART_CMD_TIMEOUT_EN.
`timescale 1ns/1ps
package uart_cmd_pkg;

  typedef enum logic {RX_IDLE, RX_RECV} rx_state_t;
  typedef enum logic {TX_IDLE, TX_TXING} tx_state_t;
  typedef enum logic {WAIT_HIGH, WAIT_LOW} asm_state_t;

  localparam int unsigned FRAME_BITS = 10;
  localparam logic [7:0]  RESP_ACK   = 8'hA5;

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: RX synchronizer, mid-bit sampling with baud/bit counters,
// LSB-first shift register, one-cycle byte-valid and framing-error pulses.
`timescale 1ns/1ps
module uart_rx_core
  import uart_cmd_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       rx_byte_vld,
  output logic       frm_err,
  output logic       rx_start
);

  // state    | meaning
  // RX_IDLE  | line idle, watching for a falling edge
  // RX_RECV  | sampling start, 8 data and stop bits mid-bit
  localparam int unsigned CW = $clog2(BAUD_DIV + 1);
  localparam logic [CW-1:0] HALF_LOAD = CW'(BAUD_DIV / 2);
  localparam logic [CW-1:0] FULL_LOAD = CW'(BAUD_DIV);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [3:0]    LAST_BIT  = 4'(FRAME_BITS - 1);

  rx_state_t     state_q, state_d;
  logic          meta_q, meta_d;
  logic          sync_q, sync_d;
  logic          prev_q, prev_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [3:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          vld_q, vld_d;
  logic          ferr_q, ferr_d;

  logic start_det;
  logic tick;
  logic last_bit;

  assign start_det = (state_q == RX_IDLE) && prev_q && !sync_q;
  assign tick      = (state_q == RX_RECV) && (baud_q == CNT_ONE);
  assign last_bit  = (bit_q == LAST_BIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RX_IDLE;
      meta_q  <= 1'b1;
      sync_q  <= 1'b1;
      prev_q  <= 1'b1;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      vld_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      meta_q  <= meta_d;
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      vld_q   <= vld_d;
      ferr_q  <= ferr_d;
    end
  end

  // A start bit that reads high on its mid-bit sample is a glitch, not a frame.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RX_IDLE: if (start_det) state_d = RX_RECV;
      RX_RECV: if (tick && ((bit_q == 4'd0 && sync_q) || last_bit)) state_d = RX_IDLE;
      default: state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    meta_d  = rx;
    sync_d  = meta_q;
    prev_d  = sync_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    vld_d   = 1'b0;
    ferr_d  = 1'b0;
    if (start_det) begin
      baud_d = HALF_LOAD;
      bit_d  = '0;
    end else if (state_q == RX_RECV) begin
      if (tick) begin
        baud_d = FULL_LOAD;
        bit_d  = bit_q + 4'd1;
        if (bit_q != 4'd0 && !last_bit) shift_d = {sync_q, shift_q[7:1]};
        if (last_bit) begin
          vld_d  = sync_q;
          ferr_d = !sync_q;
        end
      end else begin
        baud_d = baud_q - CNT_ONE;
      end
    end
  end

  assign rx_byte     = shift_q;
  assign rx_byte_vld = vld_q;
  assign frm_err     = ferr_q;
  assign rx_start    = start_det;

endmodule

// File: rtl/uart_cmd_wrapper.sv
// UART command responder: pairs received bytes into 16-bit commands and
// serializes response bytes. Define UART_CMD_TIMEOUT_EN for the WAIT_LOW timeout.
`timescale 1ns/1ps
module uart_cmd_wrapper
  import uart_cmd_pkg::*;
#(
  parameter int unsigned BAUD_DIV     = 2604,
  parameter int unsigned TIMEOUT_CLKS = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RX,
  output logic        TX,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        trmt,
  output logic        tx_done,
  output logic        frm_err
);

  // state     | meaning
  // WAIT_HIGH | expecting the high command byte
  // WAIT_LOW  | high byte held, expecting the low byte
  // TX_IDLE   | TX line high, accepting trmt
  // TX_TXING  | shifting the 10-bit frame out
  localparam int unsigned CW = $clog2(BAUD_DIV + 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(BAUD_DIV);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [3:0]    LAST_BIT  = 4'(FRAME_BITS - 1);

  logic [7:0] rx_byte;
  logic       rx_byte_vld;
  logic       rx_start;

  uart_rx_core #(.BAUD_DIV(BAUD_DIV)) u_rx (
    .clk        (clk),
    .rst        (rst),
    .rx         (RX),
    .rx_byte    (rx_byte),
    .rx_byte_vld(rx_byte_vld),
    .frm_err    (frm_err),
    .rx_start   (rx_start)
  );

  asm_state_t asm_state_q, asm_state_d;
  logic [7:0]  hi_q, hi_d;
  logic [15:0] cmd_q, cmd_d;
  logic        cmd_rdy_q, cmd_rdy_d;
  logic        timeout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      asm_state_q <= WAIT_HIGH;
      hi_q        <= '0;
      cmd_q       <= '0;
      cmd_rdy_q   <= 1'b0;
    end else begin
      asm_state_q <= asm_state_d;
      hi_q        <= hi_d;
      cmd_q       <= cmd_d;
      cmd_rdy_q   <= cmd_rdy_d;
    end
  end

  always_comb begin
    asm_state_d = asm_state_q;
    case (asm_state_q)
      WAIT_HIGH: if (rx_byte_vld) asm_state_d = WAIT_LOW;
      WAIT_LOW:  if (rx_byte_vld || frm_err || timeout) asm_state_d = WAIT_HIGH;
      default:   asm_state_d = WAIT_HIGH;
    endcase
  end

  // A new start edge retires the old command; completion outranks any clear.
  always_comb begin
    hi_d      = hi_q;
    cmd_d     = cmd_q;
    cmd_rdy_d = cmd_rdy_q;
    if (rx_start || clr_cmd_rdy) cmd_rdy_d = 1'b0;
    if (asm_state_q == WAIT_HIGH && rx_byte_vld) hi_d = rx_byte;
    if (asm_state_q == WAIT_LOW && rx_byte_vld) begin
      cmd_d     = {hi_q, rx_byte};
      cmd_rdy_d = 1'b1;
    end
  end

`ifdef UART_CMD_TIMEOUT_EN
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CLKS - 1);
  logic [31:0] to_cnt_q, to_cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) to_cnt_q <= '0;
    else     to_cnt_q <= to_cnt_d;
  end

  always_comb begin
    to_cnt_d = '0;
    if (asm_state_q == WAIT_LOW && asm_state_d == WAIT_LOW) to_cnt_d = to_cnt_q + 32'd1;
  end

  assign timeout = (asm_state_q == WAIT_LOW) && (to_cnt_q == TO_LAST);
`else
  assign timeout = 1'b0;
`endif

  assign cmd     = cmd_q;
  assign cmd_rdy = cmd_rdy_q;

  tx_state_t     tx_state_q, tx_state_d;
  logic [9:0]    tx_shift_q, tx_shift_d;
  logic [CW-1:0] tx_baud_q, tx_baud_d;
  logic [3:0]    tx_bit_q, tx_bit_d;
  logic          tx_done_q, tx_done_d;
  logic          tx_tick;
  logic          tx_last;

  assign tx_tick = (tx_state_q == TX_TXING) && (tx_baud_q == CNT_ONE);
  assign tx_last = (tx_bit_q == LAST_BIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      tx_shift_q <= '1;
      tx_baud_q  <= '0;
      tx_bit_q   <= '0;
      tx_done_q  <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_shift_q <= tx_shift_d;
      tx_baud_q  <= tx_baud_d;
      tx_bit_q   <= tx_bit_d;
      tx_done_q  <= tx_done_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    case (tx_state_q)
      TX_IDLE:  if (trmt) tx_state_d = TX_TXING;
      TX_TXING: if (tx_tick && tx_last) tx_state_d = TX_IDLE;
      default:  tx_state_d = TX_IDLE;
    endcase
  end

  // trmt during TX_TXING falls through untouched: no queueing.
  always_comb begin
    tx_shift_d = tx_shift_q;
    tx_baud_d  = tx_baud_q;
    tx_bit_d   = tx_bit_q;
    tx_done_d  = 1'b0;
    if (tx_state_q == TX_IDLE) begin
      if (trmt) begin
        tx_shift_d = {1'b1, resp, 1'b0};
        tx_baud_d  = FULL_LOAD;
        tx_bit_d   = '0;
      end
    end else if (tx_tick) begin
      tx_shift_d = {1'b1, tx_shift_q[9:1]};
      tx_baud_d  = FULL_LOAD;
      tx_bit_d   = tx_bit_q + 4'd1;
      tx_done_d  = tx_last;
    end else begin
      tx_baud_d = tx_baud_q - CNT_ONE;
    end
  end

  assign TX      = (tx_state_q == TX_TXING) ? tx_shift_q[0] : 1'b1;
  assign tx_done = tx_done_q;

endmodule

// File: tb/tb_uart_cmd_wrapper.sv
// Self-checking bench for uart_cmd_wrapper with a command scoreboard.
`timescale 1ns/1ps
module tb_uart_cmd_wrapper;
  import uart_cmd_pkg::*;

  localparam int BD = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        RX = 1'b1;
  logic        TX;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy = 1'b0;
  logic [7:0]  resp = 8'h00;
  logic        trmt = 1'b0;
  logic        tx_done;
  logic        frm_err;

  int          checks = 0;
  int          failures = 0;
  int          frm_cnt = 0;
  logic        rdy_prev = 1'b0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  uart_cmd_wrapper #(.BAUD_DIV(BD), .TIMEOUT_CLKS(500)) dut (
    .clk        (clk),
    .rst        (rst),
    .RX         (RX),
    .TX         (TX),
    .cmd        (cmd),
    .cmd_rdy    (cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy),
    .resp       (resp),
    .trmt       (trmt),
    .tx_done    (tx_done),
    .frm_err    (frm_err)
  );

  // Scoreboard consumer: every rising cmd_rdy must match the oldest expected command.
  always @(negedge clk) begin
    if (!rst) begin
      if (frm_err) frm_cnt++;
      if (cmd_rdy && !rdy_prev) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_cmd got=%h required=none", cmd);
        end else begin
          logic [15:0] e;
          e = exp_q.pop_front();
          if (cmd !== e) begin
            failures++;
            $display("FAIL cmd_value got=%h required=%h", cmd, e);
          end
        end
      end
    end
    rdy_prev = cmd_rdy;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input logic chk_drop);
    logic [9:0] fr;
    fr = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      RX = fr[i];
      if (i == 0 && chk_drop) begin
        repeat (8) @(posedge clk);
        #1;
        checks++;
        if (cmd_rdy !== 1'b0) begin
          failures++;
          $display("FAIL rdy_drop_at_start got=%b required=0", cmd_rdy);
        end
        repeat (BD - 8) @(posedge clk);
        #1;
      end else begin
        repeat (BD) @(posedge clk);
        #1;
      end
    end
    RX = 1'b1;
    repeat (BD) @(posedge clk);
    #1;
  endtask

  task automatic wait_sb(input int budget, input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s pending_cmds=%0d required=0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (TX !== 1'b1 || cmd !== 16'h0000 || cmd_rdy !== 1'b0 || tx_done !== 1'b0 || frm_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_values got TX=%b cmd=%h rdy=%b done=%b ferr=%b required 1 0000 0 0 0",
               TX, cmd, cmd_rdy, tx_done, frm_err);
    end
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_cmd_basic();
    send_byte(8'h20, 1'b1, 1'b0);
    exp_q.push_back(16'h2000);
    send_byte(8'h00, 1'b1, 1'b0);
    wait_sb(50, "cmd_2000");
    checks++;
    if (cmd_rdy !== 1'b1) begin
      failures++;
      $display("FAIL rdy_held got=%b required=1", cmd_rdy);
    end
    clr_cmd_rdy = 1'b1;
    @(posedge clk);
    #1;
    clr_cmd_rdy = 1'b0;
    checks++;
    if (cmd_rdy !== 1'b0 || cmd !== 16'h2000) begin
      failures++;
      $display("FAIL clr_cmd_rdy got rdy=%b cmd=%h required 0 2000", cmd_rdy, cmd);
    end
  endtask

  task automatic test_back_to_back();
    send_byte(8'h4B, 1'b1, 1'b0);
    exp_q.push_back(16'h4BF1);
    send_byte(8'hF1, 1'b1, 1'b0);
    wait_sb(50, "cmd_4bf1");
    send_byte(8'h40, 1'b1, 1'b1);
    exp_q.push_back(16'h4002);
    send_byte(8'h02, 1'b1, 1'b0);
    wait_sb(50, "cmd_4002");
    checks++;
    if (cmd_rdy !== 1'b1 || cmd !== 16'h4002) begin
      failures++;
      $display("FAIL b2b_final got rdy=%b cmd=%h required 1 4002", cmd_rdy, cmd);
    end
  endtask

  task automatic test_tx();
    logic [9:0] fr;
    logic       exp_tx;
    logic       exp_done;
    fr = {1'b1, RESP_ACK, 1'b0};
    resp = RESP_ACK;
    trmt = 1'b1;
    @(posedge clk);
    #1;
    trmt = 1'b0;
    for (int k = 0; k < 200; k++) begin
      exp_tx   = (k < 160) ? fr[k / BD] : 1'b1;
      exp_done = (k == 160);
      checks++;
      if (TX !== exp_tx || tx_done !== exp_done) begin
        failures++;
        $display("FAIL tx_frame clk=%0d got TX=%b done=%b required TX=%b done=%b",
                 k, TX, tx_done, exp_tx, exp_done);
      end
      if (k == 49) trmt = 1'b1;
      if (k == 50) trmt = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_frm_err();
    int f0;
    f0 = frm_cnt;
    send_byte(8'h40, 1'b1, 1'b0);
    send_byte(8'h55, 1'b0, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (frm_cnt !== f0 + 1 || cmd_rdy !== 1'b0) begin
      failures++;
      $display("FAIL frm_err got pulses=%0d rdy=%b required pulses=1 rdy=0", frm_cnt - f0, cmd_rdy);
    end
    send_byte(8'h12, 1'b1, 1'b0);
    exp_q.push_back(16'h1234);
    send_byte(8'h34, 1'b1, 1'b0);
    wait_sb(50, "cmd_1234");
  endtask

  task automatic test_reset_mid_frame();
    resp = 8'h00;
    trmt = 1'b1;
    @(posedge clk);
    #1;
    trmt = 1'b0;
    RX = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    checks++;
    if (TX !== 1'b0) begin
      failures++;
      $display("FAIL tx_low_before_reset got=%b required=0", TX);
    end
    rst = 1'b1;
    RX = 1'b1;
    #1;
    checks++;
    if (TX !== 1'b1 || cmd_rdy !== 1'b0 || cmd !== 16'h0000 || tx_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_frame got TX=%b rdy=%b cmd=%h done=%b required 1 0 0000 0",
               TX, cmd_rdy, cmd, tx_done);
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (BD) @(posedge clk);
    #1;
    send_byte(8'hAB, 1'b1, 1'b0);
    exp_q.push_back(16'hABCD);
    send_byte(8'hCD, 1'b1, 1'b0);
    wait_sb(50, "cmd_abcd");
  endtask

`ifdef UART_CMD_TIMEOUT_EN
  task automatic test_timeout();
    send_byte(8'h40, 1'b1, 1'b0);
    repeat (600) @(posedge clk);
    #1;
    send_byte(8'h11, 1'b1, 1'b0);
    exp_q.push_back(16'h1122);
    send_byte(8'h22, 1'b1, 1'b0);
    wait_sb(50, "cmd_1122");
  endtask
`endif

  initial begin
    test_reset();
    test_cmd_basic();
    test_back_to_back();
    test_tx();
    test_frm_err();
    test_reset_mid_frame();
`ifdef UART_CMD_TIMEOUT_EN
    test_timeout();
`endif
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL leftover_expected got=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
